seg7_scan_driver: RTL and testbench

// - Downstream of the GPIO APB peripheral: takes its eight per-digit 7-seg codes and drives one

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_slot_timer.sv | 63 ++++++
 rtl/seg7_scan_driver.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment display blocks.
//   SEG_OFF_DEFAULT : segment code that leaves every segment dark
//   seg7_state_e    : scan FSM states (OFF, LOAD, SCAN)
//   idx_width()     : index width for a count of items (never below 1)
//   an_onehot()     : anode pattern selecting one digit, polarity selectable
//   an_none()       : anode pattern with every digit inactive
package seg7_pkg;

    localparam int         MAX_DIGITS      = 8;
    localparam logic [7:0] SEG_OFF_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2
    } seg7_state_e;

    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic logic [MAX_DIGITS-1:0] an_onehot(input logic [2:0] idx,
                                                         input logic       act_low);
        logic [MAX_DIGITS-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return act_low ? ~sel : sel;
    endfunction

    function automatic logic [MAX_DIGITS-1:0] an_none(input logic act_low);
        return act_low ? '1 : '0;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer
// Slot and digit counters for the multiplexed display scan.
//   clock, reset : system clock, asynchronous active-high reset
//   clear        : forces both counters to zero (has priority over advance)
//   advance      : counts one cycle of the current digit slot
//   dig_idx      : digit currently being scanned
//   slot_end     : last cycle of the current slot
//   frame_end    : last cycle of the last digit slot
//   dead         : slot is still inside its anode dead-time window
module seg7_slot_timer #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 1000,
    parameter int DEAD_CYC   = 2,
    parameter int SLOT_W     = 10,
    parameter int DIG_W      = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [DIG_W-1:0] dig_idx,
    output logic             slot_end,
    output logic             frame_end,
    output logic             dead
);

    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]  dig_idx_q, dig_idx_d;
    logic              last_digit;

    assign last_digit = (dig_idx_q == DIG_W'(NUM_DIGITS - 1));
    assign slot_end   = (slot_cnt_q == SLOT_W'(CLK_DIV - 1));
    assign frame_end  = slot_end && last_digit;
    assign dead       = (slot_cnt_q < SLOT_W'(DEAD_CYC));
    assign dig_idx    = dig_idx_q;

    always_comb begin
        slot_cnt_d = slot_cnt_q;
        dig_idx_d  = dig_idx_q;
        if (clear) begin
            slot_cnt_d = '0;
            dig_idx_d  = '0;
        end else if (advance) begin
            if (slot_end) begin
                slot_cnt_d = '0;
                dig_idx_d  = last_digit ? '0 : dig_idx_q + DIG_W'(1);
            end else begin
                slot_cnt_d = slot_cnt_q + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_cnt_q <= '0;
            dig_idx_q  <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            dig_idx_q  <= dig_idx_d;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes eight 7-segment digit codes onto one shared segment bus.
// Codes are copied into a shadow at frame start so a frame never tears;
// each digit slot starts with a dead-time and the lit part is PWM-dimmed.
//   clock, reset       : system clock, asynchronous active-high reset
//   seg_in_0..seg_in_7 : per-digit segment codes (passed through unmodified)
//   enable             : 1 = scan, 0 = dark with counters cleared
//   brightness         : PWM duty, digit lit while pwm_cnt <= brightness
//   seg_out            : shared segment bus (registered)
//   an_out             : per-digit anode select, at most one active (registered)
//   frame_tick         : one-cycle pulse following each shadow load
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int         NUM_DIGITS = 8,
    parameter int         CLK_DIV    = 1000,
    parameter int         DEAD_CYC   = 2,
    parameter logic [7:0] SEG_OFF    = SEG_OFF_DEFAULT,
    parameter int         AN_ACT_LOW = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] seg_in_0,
    input  logic [7:0] seg_in_1,
    input  logic [7:0] seg_in_2,
    input  logic [7:0] seg_in_3,
    input  logic [7:0] seg_in_4,
    input  logic [7:0] seg_in_5,
    input  logic [7:0] seg_in_6,
    input  logic [7:0] seg_in_7,
    input  logic       enable,
    input  logic [3:0] brightness,
    output logic [7:0] seg_out,
    output logic [7:0] an_out,
    output logic       frame_tick
);

    localparam int   SLOT_W  = idx_width(CLK_DIV);
    localparam int   DIG_W   = idx_width(NUM_DIGITS);
    localparam logic ACT_LOW = (AN_ACT_LOW != 0);

    seg7_state_e state_q, state_d;

    logic [MAX_DIGITS-1:0][7:0] seg_in_all;
    logic [MAX_DIGITS-1:0][7:0] shadow_q, shadow_d;
    logic [3:0]                 pwm_cnt_q, pwm_cnt_d;
    logic [7:0]                 seg_out_q, seg_out_d;
    logic [7:0]                 an_out_q, an_out_d;
    logic                       frame_tick_q, frame_tick_d;

    logic             timer_clear;
    logic             timer_advance;
    logic [DIG_W-1:0] dig_idx;
    logic             slot_end;
    logic             frame_end;
    logic             dead;
    logic             lit;

    assign seg_in_all = {seg_in_7, seg_in_6, seg_in_5, seg_in_4,
                         seg_in_3, seg_in_2, seg_in_1, seg_in_0};

    // Counters stay at zero outside SCAN and whenever enable is low, so a
    // re-enabled display always restarts its frame at digit 0.
    assign timer_clear   = !enable || (state_q != SCAN);
    assign timer_advance = (state_q == SCAN);

    seg7_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .CLK_DIV    (CLK_DIV),
        .DEAD_CYC   (DEAD_CYC),
        .SLOT_W     (SLOT_W),
        .DIG_W      (DIG_W)
    ) u_slot_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (timer_clear),
        .advance    (timer_advance),
        .dig_idx    (dig_idx),
        .slot_end   (slot_end),
        .frame_end  (frame_end),
        .dead       (dead)
    );

    // Shadow captures every digit in the single LOAD cycle and holds otherwise.
    generate
        for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_shadow
            assign shadow_d[gi] = (state_q == LOAD) ? seg_in_all[gi] : shadow_q[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     state_d = LOAD;
            LOAD:    state_d = SCAN;
            SCAN:    if (slot_end && frame_end) state_d = LOAD;
            default: state_d = OFF;
        endcase
        if (!enable) begin
            state_d = OFF;
        end
    end

    // Gating with enable darkens the outputs on the very next edge after
    // enable drops, not one cycle later when the FSM reaches OFF.
    assign lit = enable && (state_q == SCAN) && !dead && (pwm_cnt_q <= brightness);

    always_comb begin
        pwm_cnt_d    = (enable && (state_q == SCAN)) ? pwm_cnt_q + 4'd1 : 4'd0;
        frame_tick_d = (state_q == LOAD);
        seg_out_d    = SEG_OFF;
        an_out_d     = an_none(ACT_LOW);
        if (lit) begin
            seg_out_d = shadow_q[dig_idx];
            an_out_d  = an_onehot(3'(dig_idx), ACT_LOW);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= OFF;
            shadow_q     <= {MAX_DIGITS{SEG_OFF}};
            pwm_cnt_q    <= '0;
            seg_out_q    <= SEG_OFF;
            an_out_q     <= an_none(ACT_LOW);
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            pwm_cnt_q    <= pwm_cnt_d;
            seg_out_q    <= seg_out_d;
            an_out_q     <= an_out_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_out    = seg_out_q;
    assign an_out     = an_out_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int NUM_DIGITS = 8;
    localparam int CLK_DIV    = 8;
    localparam int DEAD_CYC   = 2;
    localparam int FRAME_SCAN = NUM_DIGITS * CLK_DIV;
    localparam int FRAME_LEN  = 1 + FRAME_SCAN;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] brightness = 4'd15;
    logic [7:0] seg_in [NUM_DIGITS];
    logic [7:0] seg_out;
    logic [7:0] an_out;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    seg7_scan_driver #(
        .NUM_DIGITS (NUM_DIGITS),
        .CLK_DIV    (CLK_DIV),
        .DEAD_CYC   (DEAD_CYC),
        .SEG_OFF    (8'hFF),
        .AN_ACT_LOW (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .seg_in_0   (seg_in[0]),
        .seg_in_1   (seg_in[1]),
        .seg_in_2   (seg_in[2]),
        .seg_in_3   (seg_in[3]),
        .seg_in_4   (seg_in[4]),
        .seg_in_5   (seg_in[5]),
        .seg_in_6   (seg_in[6]),
        .seg_in_7   (seg_in[7]),
        .enable     (enable),
        .brightness (brightness),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    // Reference model: mode 0=dark, 1=loading, 2=scanning; m_pos is the cycle
    // position inside the scanned part of the frame, so digit = pos/CLK_DIV,
    // slot cycle = pos%CLK_DIV and PWM phase = pos%16.
    int         m_mode;
    int         m_pos;
    logic [7:0] m_shadow [NUM_DIGITS];
    logic [7:0] exp_seg;
    logic [7:0] exp_an;
    logic       exp_tick;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode   <= 0;
            m_pos    <= 0;
            exp_seg  <= 8'hFF;
            exp_an   <= 8'hFF;
            exp_tick <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) m_shadow[k] <= 8'hFF;
        end else begin
            if (m_mode == 2 && enable && (m_pos % CLK_DIV) >= DEAD_CYC
                && (m_pos % 16) <= int'(brightness)) begin
                exp_seg <= m_shadow[m_pos / CLK_DIV];
                exp_an  <= ~(8'h01 << (m_pos / CLK_DIV));
            end else begin
                exp_seg <= 8'hFF;
                exp_an  <= 8'hFF;
            end
            exp_tick <= (m_mode == 1);
            if (!enable) begin
                m_mode <= 0;
                m_pos  <= 0;
            end else if (m_mode == 0) begin
                m_mode <= 1;
            end else if (m_mode == 1) begin
                for (int k = 0; k < NUM_DIGITS; k++) m_shadow[k] <= seg_in[k];
                m_mode <= 2;
                m_pos  <= 0;
            end else if (m_pos == FRAME_SCAN - 1) begin
                m_mode <= 1;
                m_pos  <= 0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({seg_out, an_out, frame_tick} !== {8'hFF, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold: got seg=%h an=%h tick=%b, want seg=ff an=ff tick=0",
                     seg_out, an_out, frame_tick);
        end
        reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            n_checks++;
            if ({seg_out, an_out, frame_tick} !== {8'hFF, 8'hFF, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d: got seg=%h an=%h tick=%b, want seg=ff an=ff tick=0",
                         c, seg_out, an_out, frame_tick);
            end
        end
        $display("test_reset done: %0d checks, %0d failures so far", n_checks, n_fail);
    endtask

    task automatic test_scan();
        int last_tick = -1;
        int n_ticks   = 0;
        int dig;
        brightness = 4'd15;
        for (int k = 0; k < NUM_DIGITS; k++) seg_in[k] = 8'(8'h10 + k);
        enable = 1'b1;
        for (int c = 0; c < 3 * FRAME_LEN + 10; c++) begin
            @(negedge clock);
            n_checks++;
            if ({seg_out, an_out, frame_tick} !== {exp_seg, exp_an, exp_tick}) begin
                n_fail++;
                $display("FAIL scan c=%0d: got seg=%h an=%h tick=%b, want seg=%h an=%h tick=%b",
                         c, seg_out, an_out, frame_tick, exp_seg, exp_an, exp_tick);
            end
            if (an_out != 8'hFF) begin
                dig = -1;
                for (int k = 0; k < NUM_DIGITS; k++) if (!an_out[k]) dig = k;
                n_checks++;
                if ($countones(~an_out) != 1 || seg_out !== 8'(8'h10 + dig)) begin
                    n_fail++;
                    $display("FAIL scan_digit c=%0d: got seg=%h an=%h, want one anode with seg=10+digit",
                             c, seg_out, an_out);
                end
            end
            if (frame_tick) begin
                if (last_tick >= 0) begin
                    n_checks++;
                    if (c - last_tick != FRAME_LEN) begin
                        n_fail++;
                        $display("FAIL tick_spacing: got %0d cycles, want %0d", c - last_tick, FRAME_LEN);
                    end
                end
                last_tick = c;
                n_ticks++;
            end
        end
        n_checks++;
        if (n_ticks != 4) begin
            n_fail++;
            $display("FAIL tick_count: got %0d ticks, want 4", n_ticks);
        end
        $display("test_scan done: %0d checks, %0d failures so far", n_checks, n_fail);
    endtask

    task automatic test_midframe();
        int t = 0;
        int frame_no = 0;
        int seen = 0;
        while (!(m_mode == 2 && m_pos / CLK_DIV == 3) && t < 200) begin
            @(negedge clock);
            t++;
        end
        n_checks++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL midframe_wait: digit 3 not reached within 200 cycles");
        end
        seg_in[5] = 8'hAA;
        for (int c = 0; c < 2 * FRAME_LEN; c++) begin
            @(negedge clock);
            n_checks++;
            if ({seg_out, an_out, frame_tick} !== {exp_seg, exp_an, exp_tick}) begin
                n_fail++;
                $display("FAIL midframe c=%0d: got seg=%h an=%h tick=%b, want seg=%h an=%h tick=%b",
                         c, seg_out, an_out, frame_tick, exp_seg, exp_an, exp_tick);
            end
            if (frame_tick) frame_no++;
            if (an_out == 8'hDF && frame_no < 2) begin
                seen++;
                n_checks++;
                if (seg_out !== ((frame_no == 0) ? 8'h15 : 8'hAA)) begin
                    n_fail++;
                    $display("FAIL midframe_digit5 frame=%0d: got seg=%h, want %h",
                             frame_no, seg_out, (frame_no == 0) ? 8'h15 : 8'hAA);
                end
            end
        end
        n_checks++;
        if (seen != 12) begin
            n_fail++;
            $display("FAIL midframe_seen: got %0d lit digit-5 cycles, want 12", seen);
        end
        $display("test_midframe done: %0d checks, %0d failures so far", n_checks, n_fail);
    endtask

    task automatic test_pwm();
        logic [3:0] levels [3];
        levels[0] = 4'd3;
        levels[1] = 4'd0;
        levels[2] = 4'd9;
        for (int li = 0; li < 3; li++) begin
            int t = 0;
            int lit_cnt = 0;
            int want_cnt = 0;
            brightness = levels[li];
            for (int p = 0; p < FRAME_SCAN; p++)
                if ((p % CLK_DIV) >= DEAD_CYC && (p % 16) <= int'(levels[li])) want_cnt++;
            while (!frame_tick && t < 200) begin
                @(negedge clock);
                t++;
            end
            n_checks++;
            if (t >= 200) begin
                n_fail++;
                $display("FAIL pwm_wait: no frame_tick within 200 cycles");
            end
            for (int c = 0; c < FRAME_SCAN; c++) begin
                @(negedge clock);
                n_checks++;
                if ({seg_out, an_out} !== {exp_seg, exp_an} || $countones(~an_out) > 1) begin
                    n_fail++;
                    $display("FAIL pwm b=%0d c=%0d: got seg=%h an=%h, want seg=%h an=%h",
                             levels[li], c, seg_out, an_out, exp_seg, exp_an);
                end
                if (an_out != 8'hFF) lit_cnt++;
            end
            n_checks++;
            if (lit_cnt != want_cnt) begin
                n_fail++;
                $display("FAIL pwm_duty b=%0d: got %0d lit cycles, want %0d", levels[li], lit_cnt, want_cnt);
            end
        end
        brightness = 4'd15;
        $display("test_pwm done: %0d checks, %0d failures so far", n_checks, n_fail);
    endtask

    task automatic test_enable_drop();
        int t = 0;
        brightness = 4'd15;
        while (!(m_mode == 2 && m_pos == 4 * CLK_DIV + 4) && t < 200) begin
            @(negedge clock);
            t++;
        end
        n_checks++;
        if (t >= 200 || an_out !== 8'hEF) begin
            n_fail++;
            $display("FAIL drop_setup: got an=%h after %0d cycles, want an=ef", an_out, t);
        end
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_checks++;
            if ({seg_out, an_out, frame_tick} !== {8'hFF, 8'hFF, 1'b0}) begin
                n_fail++;
                $display("FAIL drop_dark c=%0d: got seg=%h an=%h tick=%b, want ff ff 0",
                         c, seg_out, an_out, frame_tick);
            end
        end
        enable = 1'b1;
        t = 0;
        while (!frame_tick && t < 10) begin
            @(negedge clock);
            t++;
        end
        n_checks++;
        if (t != 2) begin
            n_fail++;
            $display("FAIL reenable_tick: got tick after %0d cycles, want 2", t);
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if ({seg_out, an_out} !== {seg_in[0], 8'hFE}) begin
            n_fail++;
            $display("FAIL reenable_digit0: got seg=%h an=%h, want seg=%h an=fe", seg_out, an_out, seg_in[0]);
        end
        $display("test_enable_drop done: %0d checks, %0d failures so far", n_checks, n_fail);
    endtask

    task automatic test_reset_mid();
        int t = 0;
        brightness = 4'd15;
        while (!(m_mode == 2 && m_pos == 6 * CLK_DIV + 4) && t < 200) begin
            @(negedge clock);
            t++;
        end
        n_checks++;
        if (t >= 200 || an_out !== 8'hBF) begin
            n_fail++;
            $display("FAIL rstmid_setup: got an=%h after %0d cycles, want an=bf", an_out, t);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({seg_out, an_out, frame_tick} !== {8'hFF, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got seg=%h an=%h tick=%b, want ff ff 0", seg_out, an_out, frame_tick);
        end
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            n_checks++;
            if ({seg_out, an_out, frame_tick} !== {8'hFF, 8'hFF, 1'b0} || dut.state_q !== seg7_pkg::OFF) begin
                n_fail++;
                $display("FAIL rstmid_off c=%0d: got seg=%h an=%h tick=%b state=%0d, want dark and OFF",
                         c, seg_out, an_out, frame_tick, dut.state_q);
            end
        end
        $display("test_reset_mid done: %0d checks, %0d failures so far", n_checks, n_fail);
    endtask

    task automatic test_random();
        for (int k = 0; k < NUM_DIGITS; k++) seg_in[k] = 8'($urandom);
        enable = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            n_checks++;
            if ({seg_out, an_out, frame_tick} !== {exp_seg, exp_an, exp_tick} || $countones(~an_out) > 1) begin
                n_fail++;
                $display("FAIL random c=%0d: got seg=%h an=%h tick=%b, want seg=%h an=%h tick=%b",
                         c, seg_out, an_out, frame_tick, exp_seg, exp_an, exp_tick);
            end
            if ($urandom_range(0, 7) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) seg_in[$urandom_range(0, NUM_DIGITS - 1)] = 8'($urandom);
            if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
        end
        $display("test_random done: %0d checks, %0d failures so far", n_checks, n_fail);
    endtask

    initial begin
        for (int k = 0; k < NUM_DIGITS; k++) seg_in[k] = 8'h00;
        test_reset();
        test_scan();
        test_midframe();
        test_pwm();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
